pixel_fetch: RTL and testbench

PIXEL_FETCH -- requirements
Module: pixel_fetch

---
 rtl/pixel_fetch.sv | 153 +++++++++++++++
 tb/tb_pixel_fetch.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_fetch.sv
// Tile-mapped pixel fetch: 80x60 tile RAM read at pixel rate,
// host writes and a hardware fill share the idle RAM slots.
module pixel_fetch #(
  parameter int H_OFFSET  = 160,
  parameter int TILE_COLS = 80,
  parameter int TILE_ROWS = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_clk,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic        draw_active,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [12:0] wr_addr,
  input  logic [2:0]  wr_data,
  input  logic        clr_req,
  input  logic [2:0]  clr_color,
  output logic        clr_busy,
  output logic        h_sync_out,
  output logic        v_sync_out,
  output logic        r_out,
  output logic        g_out,
  output logic        b_out
);

  localparam int AW    = 13;
  localparam int DEPTH = TILE_COLS * TILE_ROWS;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;
  logic [2:0]    clr_col, clr_col_nx;

  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [2:0]    mem_wd;
  logic [2:0]    mem [DEPTH];
  logic [2:0]    rd_data;

  logic [9:0]    xo, col, row;
  logic [AW-1:0] row_w, base, addr_c;

  logic [AW-1:0] s1_addr;
  logic          s1_da, s1_hs, s1_vs;
  logic          s2_da, s2_hs, s2_vs;

  // row*TILE_COLS as shift-add for the standard 80-column map
  always_comb begin
    xo     = pix_x - 10'(H_OFFSET);
    col    = xo >> 3;
    row    = pix_y >> 3;
    row_w  = {3'b000, row};
    if (TILE_COLS == 80)
      base = (row_w << 6) + (row_w << 4);
    else
      base = row_w * AW'(TILE_COLS);
    addr_c = base + {3'b000, col};
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    clr_col_nx = clr_col;
    mem_we     = 1'b0;
    mem_wa     = '0;
    mem_wd     = '0;
    wr_ready   = 1'b0;
    unique case (state)
      IDLE: begin
        if (clr_req) begin
          state_nx   = CLEAR;
          cnt_nx     = '0;
          clr_col_nx = clr_color;
        end else if (!pix_clk) begin
          wr_ready = 1'b1;
          if (wr_valid && (wr_addr < AW'(DEPTH))) begin
            mem_we = 1'b1;
            mem_wa = wr_addr;
            mem_wd = wr_data;
          end
        end
      end
      CLEAR: begin
        if (!pix_clk) begin
          mem_we = 1'b1;
          mem_wa = cnt;
          mem_wd = clr_col;
          cnt_nx = cnt + 1'b1;
          if (cnt == LAST)
            state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign clr_busy = (state == CLEAR);

  // reset lands in CLEAR so RAM contents become defined
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      cnt     <= '0;
      clr_col <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      clr_col <= clr_col_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (pix_clk)
      rd_data <= mem[s1_addr];
    else if (mem_we)
      mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_addr    <= '0;
      s1_da      <= 1'b0;
      s1_hs      <= 1'b1;
      s1_vs      <= 1'b1;
      s2_da      <= 1'b0;
      s2_hs      <= 1'b1;
      s2_vs      <= 1'b1;
      h_sync_out <= 1'b1;
      v_sync_out <= 1'b1;
      r_out      <= 1'b0;
      g_out      <= 1'b0;
      b_out      <= 1'b0;
    end else if (pix_clk) begin
      s1_addr    <= draw_active ? addr_c : '0;
      s1_da      <= draw_active;
      s1_hs      <= h_sync;
      s1_vs      <= v_sync;
      s2_da      <= s1_da;
      s2_hs      <= s1_hs;
      s2_vs      <= s1_vs;
      h_sync_out <= s2_hs;
      v_sync_out <= s2_vs;
      {r_out, g_out, b_out} <= s2_da ? rd_data : 3'b000;
    end
  end

endmodule

// File: tb/tb_pixel_fetch.sv
// Directed bench for pixel_fetch: fill timing, pipeline
// alignment, host writes, clear and mid-fill reset.
module tb_pixel_fetch;

  localparam int DEPTH = 4800;

  logic        clk;
  logic        rst_n;
  logic        pix_clk;
  logic [9:0]  pix_x, pix_y;
  logic        h_sync, v_sync, draw_active;
  logic        wr_valid, wr_ready;
  logic [12:0] wr_addr;
  logic [2:0]  wr_data;
  logic        clr_req;
  logic [2:0]  clr_color;
  logic        clr_busy;
  logic        h_sync_out, v_sync_out, r_out, g_out, b_out;

  pixel_fetch dut (
    .clk(clk), .rst_n(rst_n), .pix_clk(pix_clk),
    .pix_x(pix_x), .pix_y(pix_y),
    .h_sync(h_sync), .v_sync(v_sync),
    .draw_active(draw_active),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .clr_color(clr_color),
    .clr_busy(clr_busy),
    .h_sync_out(h_sync_out), .v_sync_out(v_sync_out),
    .r_out(r_out), .g_out(g_out), .b_out(b_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       da;
    logic       hs;
    logic       vs;
    logic [2:0] rgb;
    logic       hso;
    logic       vso;
  } vec_t;

  vec_t       tv [9];
  logic [2:0] model [DEPTH];
  int         checks;
  int         fails;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y,
                     input logic da, input logic hs, input logic vs);
    pix_clk     = 1'b1;
    pix_x       = x;
    pix_y       = y;
    draw_active = da;
    h_sync      = hs;
    v_sync      = vs;
    step();
    pix_clk = 1'b0;
    step();
  endtask

  task automatic wr(input int a, input logic [2:0] d);
    bit ok;
    ok       = 0;
    pix_clk  = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = 13'(a);
    wr_data  = d;
    for (int k = 0; k < 8 && !ok; k++) begin
      #1;
      if (wr_ready) ok = 1;
      step();
    end
    wr_valid = 1'b0;
    chk($sformatf("wr_handshake_%0d", a), 32'(ok), 32'd1);
  endtask

  task automatic wait_clear(output int n, output bit rdy_seen);
    n        = 0;
    rdy_seen = 0;
    pix_clk  = 1'b0;
    while (clr_busy && n < 12000) begin
      step();
      n++;
      pix_clk = ~pix_clk;
      #1;
      if (clr_busy && wr_ready) rdy_seen = 1;
    end
  endtask

  task automatic chk_len(input string nm, input int n);
    checks++;
    if (n < 9597 || n > 9603) begin
      fails++;
      $display("FAIL %s: got %0d clk expected 9600 +-3", nm, n);
    end
  endtask

  task automatic readback(input string nm);
    int c, r;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (i < DEPTH) begin
        c = i % 80;
        r = i / 80;
        pix(10'(160 + c * 8 + (i % 8)), 10'(r * 8 + ((i / 8) % 8)),
            1'b1, 1'b1, 1'b1);
      end else begin
        pix(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
      end
      if (i >= 2)
        chk($sformatf("%s_tile%0d", nm, i - 2),
            32'({r_out, g_out, b_out}), 32'(model[i - 2]));
    end
  endtask

  int n;
  bit rdy;

  initial begin
    checks = 0;
    fails  = 0;
    rst_n = 1'b0; pix_clk = 1'b0;
    pix_x = '0; pix_y = '0;
    h_sync = 1'b1; v_sync = 1'b1; draw_active = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    clr_req = 1'b0; clr_color = '0;

    tv[0] = '{10'd160, 10'd0,   1'b1, 1'b1, 1'b1, 3'b100, 1'b1, 1'b1};
    tv[1] = '{10'd168, 10'd8,   1'b1, 1'b1, 1'b1, 3'b011, 1'b1, 1'b1};
    tv[2] = '{10'd160, 10'd0,   1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1};
    tv[3] = '{10'd167, 10'd7,   1'b1, 1'b1, 1'b1, 3'b100, 1'b1, 1'b1};
    tv[4] = '{10'd175, 10'd15,  1'b1, 1'b1, 1'b1, 3'b011, 1'b1, 1'b1};
    tv[5] = '{10'd168, 10'd0,   1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0};
    tv[6] = '{10'd0,   10'd0,   1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0};
    tv[7] = '{10'd799, 10'd479, 1'b1, 1'b1, 1'b1, 3'b101, 1'b1, 1'b1};
    tv[8] = '{10'd160, 10'd0,   1'b1, 1'b0, 1'b1, 3'b100, 1'b0, 1'b1};

    repeat (3) step();
    chk("rst_hsync", 32'(h_sync_out), 32'd1);
    chk("rst_vsync", 32'(v_sync_out), 32'd1);
    chk("rst_rgb", 32'({r_out, g_out, b_out}), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);

    rst_n = 1'b1;
    #1;
    chk("post_rst_busy", 32'(clr_busy), 32'd1);
    wait_clear(n, rdy);
    chk_len("init_fill_len", n);
    chk("init_fill_ready", 32'(rdy), 32'd0);
    chk("init_fill_done", 32'(clr_busy), 32'd0);
    for (int k = 0; k < 4; k++) begin
      pix_clk = ~pix_clk;
      #1;
      chk($sformatf("ready_toggle_%0d", k), 32'(wr_ready), 32'(!pix_clk));
      step();
    end
    for (int i = 0; i < DEPTH; i++) model[i] = 3'b000;

    wr(0, 3'b100);    model[0]    = 3'b100;
    wr(81, 3'b011);   model[81]   = 3'b011;
    wr(4799, 3'b101); model[4799] = 3'b101;
    wr(4800, 3'b111);

    for (int i = 0; i < 11; i++) begin
      if (i < 9) pix(tv[i].x, tv[i].y, tv[i].da, tv[i].hs, tv[i].vs);
      else       pix(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
      if (i >= 2) begin
        chk($sformatf("vec%0d_rgb", i - 2),
            32'({r_out, g_out, b_out}), 32'(tv[i - 2].rgb));
        chk($sformatf("vec%0d_hs", i - 2),
            32'(h_sync_out), 32'(tv[i - 2].hso));
        chk($sformatf("vec%0d_vs", i - 2),
            32'(v_sync_out), 32'(tv[i - 2].vso));
      end
    end

    readback("rb_oob");

    clr_req = 1'b1; clr_color = 3'b010;
    wr_valid = 1'b1; wr_addr = 13'd5; wr_data = 3'b111;
    pix_clk = 1'b0;
    #1;
    chk("clr_vs_wr_ready", 32'(wr_ready), 32'd0);
    step();
    clr_req = 1'b0;
    chk("clr_busy_set", 32'(clr_busy), 32'd1);
    wait_clear(n, rdy);
    wr_valid = 1'b0;
    chk_len("clr_len", n);
    chk("clr_ready_low", 32'(rdy), 32'd0);
    for (int i = 0; i < DEPTH; i++) model[i] = 3'b010;
    readback("rb_green");

    clr_req = 1'b1; clr_color = 3'b110;
    step();
    clr_req = 1'b0;
    h_sync = 1'b0; v_sync = 1'b0; draw_active = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      pix_clk = ~pix_clk;
      step();
    end
    chk("mid_fill_busy", 32'(clr_busy), 32'd1);
    chk("mid_fill_hs", 32'(h_sync_out), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_hs", 32'(h_sync_out), 32'd1);
    chk("abort_vs", 32'(v_sync_out), 32'd1);
    chk("abort_rgb", 32'({r_out, g_out, b_out}), 32'd0);
    chk("abort_ready", 32'(wr_ready), 32'd0);
    h_sync = 1'b1; v_sync = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    wait_clear(n, rdy);
    chk_len("refill_len", n);
    for (int i = 0; i < DEPTH; i++) model[i] = 3'b000;
    readback("rb_refill");

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
